// File: rtl/metadata_pkg.sv
// Shared types and PLRU tree helpers for the set-associative metadata store.
// Trees up to 8 ways are handled with a fixed 7-bit working vector.
package metadata_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} flush_state_e;

    function automatic int way_bits(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int plru_bits(int n);
        return (n > 1) ? n - 1 : 1;
    endfunction

    // Follow the tree from the root; a 0 bit steers to the lower half.
    function automatic logic [2:0] plru_victim(logic [6:0] bits, int lvls);
        logic [2:0] w;
        int node;
        w = '0;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < lvls) begin
                w = {w[1:0], bits[node]};
                node = 2 * node + 1 + int'(bits[node]);
            end
        end
        return w;
    endfunction

    function automatic logic [6:0] plru_touch(logic [6:0] bits,
                                              logic [2:0] way,
                                              int lvls);
        logic [6:0] nb;
        logic d;
        int node;
        nb = bits;
        node = 0;
        for (int l = 0; l < 3; l++) begin
            if (l < lvls) begin
                d = way[lvls-1-l];
                nb[node] = ~d;
                node = 2 * node + 1 + int'(d);
            end
        end
        return nb;
    endfunction

endpackage

// File: rtl/metadata_assoc_if.sv
// Writeback channel used by the flush walker to stream dirty lines out.
interface metadata_assoc_if #(
    parameter int SET_BITS = 2,
    parameter int WAY_BITS = 1,
    parameter int TAG_SIZE = 29
);
    logic                wb_valid;
    logic                wb_ready;
    logic [SET_BITS-1:0] wb_set;
    logic [WAY_BITS-1:0] wb_way;
    logic [TAG_SIZE-1:0] wb_tag;

    modport master (
        output wb_valid, wb_set, wb_way, wb_tag,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_set, wb_way, wb_tag,
        output wb_ready
    );
endinterface

// File: rtl/metadata_assoc_plru_tree.sv
// Per-set tree-PLRU bits: victim decode for the looked-up set and
// a touch port that points the path away from the most recent way.
module plru_tree
    import metadata_pkg::*;
#(
    parameter  int NUM_SETS = 4,
    parameter  int NUM_WAYS = 2,
    localparam int SET_BITS = $clog2(NUM_SETS),
    localparam int WAY_BITS = way_bits(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SET_BITS-1:0] rd_set,
    output logic [WAY_BITS-1:0] victim,
    input  logic                touch_en,
    input  logic [SET_BITS-1:0] touch_set,
    input  logic [WAY_BITS-1:0] touch_way
);
    localparam int LVLS = $clog2(NUM_WAYS);
    localparam int PB   = plru_bits(NUM_WAYS);

    generate
        if (NUM_WAYS > 1) begin : g_tree
            logic [NUM_SETS-1:0][PB-1:0] bits_q;
            logic [6:0] rd_bits;
            logic [6:0] tc_bits;
            logic [6:0] bits_d;

            always_comb begin
                rd_bits = '0;
                tc_bits = '0;
                rd_bits[PB-1:0] = bits_q[rd_set];
                tc_bits[PB-1:0] = bits_q[touch_set];
                bits_d = plru_touch(tc_bits, 3'(touch_way), LVLS);
            end

            assign victim = WAY_BITS'(plru_victim(rd_bits, LVLS));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    bits_q <= '0;
                end else if (touch_en) begin
                    bits_q[touch_set] <= bits_d[PB-1:0];
                end
            end
        end else begin : g_none
            logic unused;
            assign unused = ^{clk, reset_n, rd_set, touch_en,
                              touch_set, touch_way};
            assign victim = '0;
        end
    endgenerate
endmodule

// File: rtl/metadata_assoc.sv
// N-way tag/valid/dirty store with PLRU replacement and a flush walker.
// Optional METADATA_ASSOC_PERF_CNT_EN adds saturating hit/miss counters.
module metadata_assoc
    import metadata_pkg::*;
#(
    parameter  int NUM_SETS  = 4,
    parameter  int NUM_WAYS  = 2,
    parameter  int TAG_SIZE  = 29,
    parameter  int READ_ONLY = 0,
    localparam int SET_BITS  = $clog2(NUM_SETS),
    localparam int WAY_BITS  = way_bits(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SET_BITS-1:0] set,
    input  logic [TAG_SIZE-1:0] tag,
    input  logic                lookup_en,
    output logic                hit,
    output logic [WAY_BITS-1:0] hit_way,
    output logic [WAY_BITS-1:0] victim_way,
    output logic                victim_dirty,
    output logic [TAG_SIZE-1:0] victim_tag,
    input  logic                install,
    input  logic                set_dirty,
    input  logic                clear_dirty,
    input  logic                invalidate,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                flush_done,
`ifdef METADATA_ASSOC_PERF_CNT_EN
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
`endif
    metadata_assoc_if.master    wb
);
    localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(NUM_SETS - 1);
    localparam logic [WAY_BITS-1:0] WAY_LAST = WAY_BITS'(NUM_WAYS - 1);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, dirty_q;
    logic [TAG_SIZE-1:0] tag_q [NUM_SETS][NUM_WAYS];

    flush_state_e        state_q;
    logic [SET_BITS-1:0] ptr_set_q;
    logic [WAY_BITS-1:0] ptr_way_q;
    logic                busy_q, done_q, wbv_q;

    logic [NUM_WAYS-1:0] match;
    logic [WAY_BITS-1:0] inv_way, plru_way, touch_way;
    logic                any_inv, upd_en, touch_en;
    logic                do_inv, do_ins, do_clr, do_set;
    logic                ptr_vd, last, scan_clr, wb_clr;

    always_comb begin
        match   = '0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            match[w] = valid_q[set][w] && tag_q[set][w] == tag;
            if (match[w]) hit_way = WAY_BITS'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_BITS'(w);
            end
        end
    end

    assign hit          = |match;
    assign victim_way   = any_inv ? inv_way : plru_way;
    assign victim_dirty = (READ_ONLY == 0) && valid_q[set][victim_way]
                          && dirty_q[set][victim_way];
    assign victim_tag   = tag_q[set][victim_way];

    // Host updates are frozen for the whole walk including the done beat.
    assign upd_en = !(busy_q || done_q);

    always_comb begin
        do_inv = upd_en && invalidate && hit;
        do_ins = upd_en && !invalidate && install;
        do_clr = upd_en && !invalidate && !install && clear_dirty && hit;
        do_set = upd_en && !invalidate && !install && !clear_dirty
                 && set_dirty && hit && (READ_ONLY == 0);
    end

    assign touch_en  = do_ins || (upd_en && lookup_en && hit);
    assign touch_way = do_ins ? victim_way : hit_way;

    plru_tree #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_set    (set),
        .victim    (plru_way),
        .touch_en  (touch_en),
        .touch_set (set),
        .touch_way (touch_way)
    );

    assign ptr_vd   = valid_q[ptr_set_q][ptr_way_q]
                      && dirty_q[ptr_set_q][ptr_way_q];
    assign last     = (ptr_set_q == SET_LAST) && (ptr_way_q == WAY_LAST);
    assign scan_clr = (state_q == SCAN) && !ptr_vd;
    assign wb_clr   = (state_q == WB) && wb.wb_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (scan_clr) valid_q[ptr_set_q][ptr_way_q] <= 1'b0;
            if (wb_clr) begin
                valid_q[ptr_set_q][ptr_way_q] <= 1'b0;
                dirty_q[ptr_set_q][ptr_way_q] <= 1'b0;
            end
            if (do_inv) valid_q[set][hit_way] <= 1'b0;
            if (do_ins) begin
                valid_q[set][victim_way] <= 1'b1;
                dirty_q[set][victim_way] <= 1'b0;
            end
            if (do_clr) dirty_q[set][hit_way] <= 1'b0;
            if (do_set) dirty_q[set][hit_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_ins) tag_q[set][victim_way] <= tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_set_q <= '0;
            ptr_way_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wbv_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q   <= SCAN;
                        busy_q    <= 1'b1;
                        ptr_set_q <= '0;
                        ptr_way_q <= '0;
                    end
                end
                SCAN, WB: begin
                    if (state_q == SCAN && ptr_vd) begin
                        state_q <= WB;
                        wbv_q   <= 1'b1;
                    end else if (state_q == SCAN || wb.wb_ready) begin
                        wbv_q <= 1'b0;
                        if (last) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            ptr_set_q <= '0;
                            ptr_way_q <= '0;
                        end else begin
                            state_q <= SCAN;
                            if (ptr_way_q == WAY_LAST) begin
                                ptr_way_q <= '0;
                                ptr_set_q <= ptr_set_q + SET_BITS'(1);
                            end else begin
                                ptr_way_q <= ptr_way_q + WAY_BITS'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flush_busy  = busy_q;
    assign flush_done  = done_q;
    assign wb.wb_valid = wbv_q;
    assign wb.wb_set   = ptr_set_q;
    assign wb.wb_way   = ptr_way_q;
    assign wb.wb_tag   = tag_q[ptr_set_q][ptr_way_q];

`ifdef METADATA_ASSOC_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lookup_en && !busy_q) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(match))
        else $error("metadata_assoc: multiple ways match one tag");
endmodule

// File: tb/tb_metadata_assoc.sv
// Directed bench for metadata_assoc: lookup/install/PLRU vectors,
// then flush walks with and without writeback back-pressure.
module tb_metadata_assoc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  set;
    logic [28:0] tag;
    logic        lookup_en, install, set_dirty, clear_dirty;
    logic        invalidate, flush_req;
    logic        hit, hit_way, victim_way, victim_dirty;
    logic        flush_busy, flush_done;
    logic [28:0] victim_tag;
`ifdef METADATA_ASSOC_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    metadata_assoc_if #(.SET_BITS(2), .WAY_BITS(1), .TAG_SIZE(29)) wb ();

    metadata_assoc #(
        .NUM_SETS (4),
        .NUM_WAYS (2),
        .TAG_SIZE (29),
        .READ_ONLY(0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .set          (set),
        .tag          (tag),
        .lookup_en    (lookup_en),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .install      (install),
        .set_dirty    (set_dirty),
        .clear_dirty  (clear_dirty),
        .invalidate   (invalidate),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
`ifdef METADATA_ASSOC_PERF_CNT_EN
        .hit_count    (hit_count),
        .miss_count   (miss_count),
`endif
        .wb           (wb.master)
    );

    typedef enum logic [2:0] {PEEK, LOOK, INST, SETD, CLRD, INVSD} op_e;

    typedef struct {
        op_e         op;
        logic [1:0]  s;
        logic [28:0] t;
        logic        h;
        logic        hw;
        logic        vw;
        logic        vd;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        lookup_en   = 1'b0;
        install     = 1'b0;
        set_dirty   = 1'b0;
        clear_dirty = 1'b0;
        invalidate  = 1'b0;
        flush_req   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek_miss(string name, logic [1:0] s, logic [28:0] t);
        idle_inputs();
        set = s;
        tag = t;
        #1;
        chk(name, 32'(hit), 32'd0);
    endtask

    initial begin
        int busy_cnt, done_cnt, beats;
        logic [1:0]  b_set;
        logic        b_way;
        logic [28:0] b_tag;
        logic        seen;

        idle_inputs();
        set = '0;
        tag = '0;
        wb.wb_ready = 1'b1;

        //     op     set   tag            hit hw vw vd
        vq.push_back('{PEEK,  2'd1, 29'h10,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{INST,  2'd1, 29'h10,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{INST,  2'd1, 29'h20,       1'b0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{LOOK,  2'd1, 29'h10,       1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{PEEK,  2'd1, 29'h20,       1'b1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{LOOK,  2'd1, 29'h20,       1'b1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{PEEK,  2'd1, 29'h30,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{INST,  2'd1, 29'h30,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{PEEK,  2'd1, 29'h10,       1'b0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{SETD,  2'd1, 29'h20,       1'b1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{PEEK,  2'd1, 29'h30,       1'b1, 1'b0, 1'b1, 1'b1});
        vq.push_back('{PEEK,  2'd0, 29'h20,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{CLRD,  2'd1, 29'h20,       1'b1, 1'b1, 1'b1, 1'b1});
        vq.push_back('{PEEK,  2'd1, 29'h20,       1'b1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{SETD,  2'd1, 29'h20,       1'b1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{INST,  2'd3, 29'h1FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{PEEK,  2'd3, 29'h1FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0});
        vq.push_back('{INST,  2'd0, 29'h77,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{INVSD, 2'd0, 29'h77,       1'b1, 1'b0, 1'b1, 1'b0});
        vq.push_back('{PEEK,  2'd0, 29'h77,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{INST,  2'd0, 29'h77,       1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{PEEK,  2'd0, 29'h77,       1'b1, 1'b0, 1'b1, 1'b0});

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset busy", 32'(flush_busy), 32'd0);
        chk("reset done", 32'(flush_done), 32'd0);
        chk("reset wb_valid", 32'(wb.wb_valid), 32'd0);
        @(negedge clk);

        foreach (vq[i]) begin
            idle_inputs();
            set = vq[i].s;
            tag = vq[i].t;
            case (vq[i].op)
                LOOK:  lookup_en = 1'b1;
                INST:  install = 1'b1;
                SETD:  set_dirty = 1'b1;
                CLRD:  clear_dirty = 1'b1;
                INVSD: begin
                    invalidate = 1'b1;
                    set_dirty  = 1'b1;
                end
                default: ;
            endcase
            #1;
            chk($sformatf("v%0d hit", i), 32'(hit), 32'(vq[i].h));
            chk($sformatf("v%0d hit_way", i), 32'(hit_way), 32'(vq[i].hw));
            chk($sformatf("v%0d victim_way", i), 32'(victim_way), 32'(vq[i].vw));
            chk($sformatf("v%0d victim_dirty", i), 32'(victim_dirty), 32'(vq[i].vd));
            tick();
        end

        idle_inputs();
        set = 2'd1;
        tag = 29'h0;
        #1;
        chk("set1 victim_way", 32'(victim_way), 32'd1);
        chk("set1 victim_tag", 32'(victim_tag), 32'h20);
        chk("set1 victim_dirty", 32'(victim_dirty), 32'd1);

        // Flush with writeback always ready.
        @(negedge clk);
        wb.wb_ready = 1'b1;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        beats = 0;
        b_set = '0;
        b_way = 1'b0;
        b_tag = '0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (flush_busy) busy_cnt++;
            if (flush_done) done_cnt++;
            if (wb.wb_valid && wb.wb_ready) begin
                beats++;
                b_set = wb.wb_set;
                b_way = wb.wb_way;
                b_tag = wb.wb_tag;
            end
            @(negedge clk);
        end
        chk("flush1 busy cycles", 32'(busy_cnt), 32'd9);
        chk("flush1 done pulses", 32'(done_cnt), 32'd1);
        chk("flush1 wb beats", 32'(beats), 32'd1);
        chk("flush1 wb_set", 32'(b_set), 32'd1);
        chk("flush1 wb_way", 32'(b_way), 32'd1);
        chk("flush1 wb_tag", 32'(b_tag), 32'h20);
        peek_miss("post flush s0 77", 2'd0, 29'h77);
        peek_miss("post flush s1 20", 2'd1, 29'h20);
        peek_miss("post flush s1 30", 2'd1, 29'h30);
        peek_miss("post flush s3 max", 2'd3, 29'h1FFFFFFF);

        // Flush stalled by writeback, then reset in the middle of WB.
        @(negedge clk);
        set = 2'd2;
        tag = 29'h55;
        install = 1'b1;
        tick();
        idle_inputs();
        set_dirty = 1'b1;
        tick();
        idle_inputs();
        wb.wb_ready = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            #1;
            if (wb.wb_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("flush2 wb offered", 32'(seen), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d wb_valid", k), 32'(wb.wb_valid), 32'd1);
            chk($sformatf("hold%0d wb_set", k), 32'(wb.wb_set), 32'd2);
            chk($sformatf("hold%0d wb_way", k), 32'(wb.wb_way), 32'd0);
            chk($sformatf("hold%0d wb_tag", k), 32'(wb.wb_tag), 32'h55);
            chk($sformatf("hold%0d busy", k), 32'(flush_busy), 32'd1);
            @(negedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(flush_busy), 32'd0);
        chk("abort wb_valid", 32'(wb.wb_valid), 32'd0);
        chk("abort done", 32'(flush_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wb.wb_ready = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (flush_done || flush_busy) done_cnt++;
            @(negedge clk);
        end
        chk("abort no done", 32'(done_cnt), 32'd0);
        peek_miss("abort s2 55", 2'd2, 29'h55);
        chk("abort victim_dirty", 32'(victim_dirty), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1, "timeout");
    end
endmodule
